mem_port_arbiter: RTL and testbench

- Parametrised N-port arbiter between block-granular cache ports (I-cache, D-cache, future ports) and the single unified_mem port.
- Replaces the hard-wired two-cache sharing of memory with explicit per-port request/response handshakes, selectable round-robin or fixed priority, and a memory-timeout watchdog.
- Sits between the cache controllers and unified_mem; exactly one memory transaction is outstanding at a time.

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the N-port block arbiter, bundled for module ports.
// slave: arbiter side; master: requesters plus memory model side.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 14,
  parameter int BLK_W     = 64
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*BLK_W-1:0]  req_wdata;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic                        rsp_err;
  logic [BLK_W-1:0]            rsp_rdata;
  logic [NUM_PORTS-1:0]        grant;
  logic [ADDR_W-1:0]           m_addr;
  logic                        m_re;
  logic                        m_we;
  logic [BLK_W-1:0]            m_wr_data;
  logic [BLK_W-1:0]            m_rd_data;
  logic                        m_rdy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, m_rd_data, m_rdy,
    output rsp_valid, rsp_err, rsp_rdata, grant, m_addr, m_re, m_we, m_wr_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, m_rd_data, m_rdy,
    input  rsp_valid, rsp_err, rsp_rdata, grant, m_addr, m_re, m_we, m_wr_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-port block arbiter onto one memory port, one transaction in flight; round-robin or fixed priority.
// Grant on the edge after a request, response one edge after m_rdy or watchdog expiry; others wait held.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 14,
  parameter int BLK_W     = 64,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 64
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST  = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW-1:0]  PTR_INIT = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  pick;
  logic           pick_vld;
  logic [WDW-1:0] wdog;
  int             idx;

  // Winner selection; the scan runs from the far end so the nearest candidate is assigned last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    if (PRIO_MODE != 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (bus.req_valid[PW'(i)]) begin
          pick     = PW'(i);
          pick_vld = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (bus.req_valid[PW'(idx)]) begin
          pick     = PW'(idx);
          pick_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= PTR_INIT;
      wdog          <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.grant     <= '0;
      bus.m_addr    <= '0;
      bus.m_re      <= 1'b0;
      bus.m_we      <= 1'b0;
      bus.m_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            bus.m_addr    <= bus.req_addr[pick*ADDR_W +: ADDR_W];
            bus.m_wr_data <= bus.req_wdata[pick*BLK_W +: BLK_W];
            bus.m_we      <= bus.req_we[pick];
            bus.m_re      <= ~bus.req_we[pick];
            bus.grant     <= NUM_PORTS'(1) << pick;
            wdog          <= '0;
            if (PRIO_MODE == 0) ptr <= pick;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // m_rdy takes precedence over a watchdog expiry in the same cycle.
          if (bus.m_rdy) begin
            if (bus.m_re) bus.rsp_rdata <= bus.m_rd_data;
            bus.m_re      <= 1'b0;
            bus.m_we      <= 1'b0;
            bus.rsp_valid <= bus.grant;
            bus.rsp_err   <= 1'b0;
            state         <= RESP;
          end else if (TIMEOUT != 0) begin
            if (wdog == WD_LAST) begin
              bus.m_re      <= 1'b0;
              bus.m_we      <= 1'b0;
              bus.rsp_valid <= bus.grant;
              bus.rsp_err   <= 1'b1;
              state         <= RESP;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
        end
        RESP: begin
          bus.rsp_valid <= '0;
          bus.rsp_err   <= 1'b0;
          bus.grant     <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin 3-port and a fixed-priority 2-port instance,
// a transaction-level reference model checked every cycle, plus directed scenario checks.
module tb_mem_port_arbiter;
  localparam int TOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(14), .BLK_W(64)) bi ();
  mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(14), .BLK_W(64)) bf ();

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(14), .BLK_W(64), .PRIO_MODE(0), .TIMEOUT(TOUT))
    u_rr (.clk(clk), .rst(rst), .bus(bi.slave));
  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(14), .BLK_W(64), .PRIO_MODE(1), .TIMEOUT(TOUT))
    u_fx (.clk(clk), .rst(rst), .bus(bf.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (one entry per DUT) ----------------
  int   np[2]   = '{3, 2};
  int   mode[2] = '{0, 1};
  bit   in_flight[2], responding[2], cur_we[2], exp_err[2];
  int   cur_port[2], age[2], last_g[2];
  logic [13:0] exp_addr[2];
  logic [63:0] exp_wdata[2], exp_rdata[2];
  bit   started = 1'b0;

  function automatic int choose(input int d, input logic [2:0] rv);
    int i;
    if (mode[d] == 1) begin
      for (int p = 0; p < np[d]; p++) if (rv[p]) return p;
    end else begin
      for (int k = 1; k <= np[d]; k++) begin
        i = (last_g[d] + k) % np[d];
        if (rv[i]) return i;
      end
    end
    return 0;
  endfunction

  task automatic model_step(input int d, input logic [2:0] rv, input logic [2:0] we,
                            input logic [41:0] ad, input logic [191:0] wd,
                            input logic rdy, input logic [63:0] rd);
    int g;
    if (rst) begin
      in_flight[d] = 0; responding[d] = 0; exp_err[d] = 0;
      exp_addr[d] = '0; exp_wdata[d] = '0; exp_rdata[d] = '0;
      last_g[d] = np[d] - 1; cur_port[d] = 0; cur_we[d] = 0; age[d] = 0;
    end else if (responding[d]) begin
      responding[d] = 0;
    end else if (in_flight[d]) begin
      if (rdy) begin
        if (!cur_we[d]) exp_rdata[d] = rd;
        exp_err[d] = 0; in_flight[d] = 0; responding[d] = 1;
      end else if (age[d] == TOUT - 1) begin
        exp_err[d] = 1; in_flight[d] = 0; responding[d] = 1;
      end else begin
        age[d]++;
      end
    end else if (rv != 0) begin
      g = choose(d, rv);
      cur_port[d] = g; cur_we[d] = we[g];
      exp_addr[d] = ad[g*14 +: 14]; exp_wdata[d] = wd[g*64 +: 64];
      age[d] = 0; in_flight[d] = 1;
      if (mode[d] == 0) last_g[d] = g;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, bi.req_valid, bi.req_we, bi.req_addr, bi.req_wdata, bi.m_rdy, bi.m_rd_data);
    model_step(1, {1'b0, bf.req_valid}, {1'b0, bf.req_we}, {14'b0, bf.req_addr},
               {64'b0, bf.req_wdata}, bf.m_rdy, bf.m_rd_data);
    started = 1'b1;
  end

  task automatic compare(input int d, input logic [2:0] gr, input logic [2:0] rv, input logic err,
                         input logic re, input logic we, input logic [13:0] ma,
                         input logic [63:0] wd, input logic [63:0] rd);
    logic [2:0] oh;
    oh = 3'(1 << cur_port[d]);
    chk($sformatf("d%0d grant", d), 64'(gr), 64'((in_flight[d] || responding[d]) ? oh : 3'b0));
    chk($sformatf("d%0d rsp_valid", d), 64'(rv), 64'(responding[d] ? oh : 3'b0));
    chk($sformatf("d%0d rsp_err", d), 64'(err), 64'(responding[d] && exp_err[d]));
    chk($sformatf("d%0d m_re", d), 64'(re), 64'(in_flight[d] && !cur_we[d]));
    chk($sformatf("d%0d m_we", d), 64'(we), 64'(in_flight[d] && cur_we[d]));
    chk($sformatf("d%0d m_addr", d), 64'(ma), 64'(exp_addr[d]));
    chk($sformatf("d%0d m_wr_data", d), wd, exp_wdata[d]);
    chk($sformatf("d%0d rsp_rdata", d), rd, exp_rdata[d]);
  endtask

  always @(negedge clk) begin
    if (started) begin
      compare(0, bi.grant, bi.rsp_valid, bi.rsp_err, bi.m_re, bi.m_we, bi.m_addr,
              bi.m_wr_data, bi.rsp_rdata);
      compare(1, {1'b0, bf.grant}, {1'b0, bf.rsp_valid}, bf.rsp_err, bf.m_re, bf.m_we,
              bf.m_addr, bf.m_wr_data, bf.rsp_rdata);
    end
  end

  // ---------------- memory responder, requesters and transaction monitor ----------------
  int   lat[2]    = '{0, 0};
  int   cnt[2][3] = '{'{0, 0, 0}, '{0, 0, 0}};
  logic [63:0] rd_val[2] = '{64'h0, 64'h0};
  int   en_len[2]   = '{0, 0};
  bit   saw_re[2], saw_we[2];
  int   last_len[2], last_port[2];
  bit   last_err[2], last_re[2], last_we[2];
  logic [13:0] seen_addr[2];
  logic [63:0] seen_wd[2];
  int   done_cnt[2] = '{0, 0};
  int   order0[$];
  int   order1[$];
  bit   gap_on = 1'b0;
  int   cur_gap = 0;
  int   max_gap = 0;

  task automatic observe(input int d, input logic re, input logic we, input logic [2:0] rsv,
                         input logic err, input logic [13:0] ma, input logic [63:0] mwd,
                         output logic rdy);
    int p;
    rdy = 1'b0;
    if (rst) begin
      en_len[d] = 0; saw_re[d] = 0; saw_we[d] = 0;
    end else if (re || we) begin
      en_len[d]++;
      if (re) saw_re[d] = 1;
      if (we) saw_we[d] = 1;
      seen_addr[d] = ma; seen_wd[d] = mwd;
      rdy = (lat[d] != 0) && (en_len[d] == lat[d]);
    end
    if (rsv != 3'b0) begin
      p = 0;
      for (int i = 0; i < 3; i++) if (rsv[i]) p = i;
      last_len[d] = en_len[d]; last_err[d] = err; last_port[d] = p;
      last_re[d] = saw_re[d]; last_we[d] = saw_we[d];
      if (d == 0) order0.push_back(p); else order1.push_back(p);
      done_cnt[d]++;
      en_len[d] = 0; saw_re[d] = 0; saw_we[d] = 0;
    end
    if (d == 0) begin
      if (re) begin
        if (gap_on && cur_gap > max_gap) max_gap = cur_gap;
        cur_gap = 0; gap_on = 1'b1;
      end else if (gap_on) begin
        cur_gap++;
      end
    end
  endtask

  always @(negedge clk) begin : mem_side
    logic r0, r1;
    observe(0, bi.m_re, bi.m_we, bi.rsp_valid, bi.rsp_err, bi.m_addr, bi.m_wr_data, r0);
    observe(1, bf.m_re, bf.m_we, {1'b0, bf.rsp_valid}, bf.rsp_err, bf.m_addr, bf.m_wr_data, r1);
    bi.m_rdy = r0;
    bf.m_rdy = r1;
    bi.m_rd_data = rd_val[0] ^ {50'b0, bi.m_addr};
    bf.m_rd_data = rd_val[1] ^ {50'b0, bf.m_addr};
    for (int p = 0; p < 3; p++) if (bi.rsp_valid[p] && cnt[0][p] > 0) cnt[0][p]--;
    for (int p = 0; p < 2; p++) if (bf.rsp_valid[p] && cnt[1][p] > 0) cnt[1][p]--;
    bi.req_valid = {cnt[0][2] > 0, cnt[0][1] > 0, cnt[0][0] > 0};
    bf.req_valid = {cnt[1][1] > 0, cnt[1][0] > 0};
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (done_cnt[d] < target && n < budget) begin
      cyc();
      n++;
    end
    chk(nm, 64'(done_cnt[d] >= target), 64'd1);
  endtask

  initial begin
    int base;
    int n;
    bi.req_valid = '0; bi.req_we = '0; bi.req_addr = '0; bi.req_wdata = '0;
    bi.m_rdy = 1'b0; bi.m_rd_data = '0;
    bf.req_valid = '0; bf.req_we = '0; bf.req_addr = '0; bf.req_wdata = '0;
    bf.m_rdy = 1'b0; bf.m_rd_data = '0;
    rst = 1'b1;
    cyc(3);
    chk("reset grant", 64'(bi.grant), 64'd0);
    chk("reset m_re", 64'(bi.m_re), 64'd0);
    chk("reset rsp_valid", 64'(bi.rsp_valid), 64'd0);
    chk("reset rsp_rdata", bi.rsp_rdata, 64'd0);
    rst = 1'b0;

    // Round-robin, all three ports requesting, single-cycle memory.
    bi.req_addr = {14'h102, 14'h101, 14'h100};
    lat[0] = 1; rd_val[0] = 64'h5555_0000_0000_0000;
    order0.delete(); gap_on = 1'b0; max_gap = 0;
    cnt[0][0] = 2; cnt[0][1] = 1; cnt[0][2] = 1;
    wait_done(0, 4, 60, "rr done");
    chk("rr count", 64'(order0.size()), 64'd4);
    if (order0.size() == 4) begin
      chk("rr grant0", 64'(order0[0]), 64'd0);
      chk("rr grant1", 64'(order0[1]), 64'd1);
      chk("rr grant2", 64'(order0[2]), 64'd2);
      chk("rr grant3", 64'(order0[3]), 64'd0);
    end
    chk("rr max m_re gap", 64'(max_gap), 64'd2);
    cyc(2);

    // Single read on port 1 with a 4-cycle memory.
    base = done_cnt[0];
    bi.req_addr[14 +: 14] = 14'h0123;
    lat[0] = 4; rd_val[0] = 64'hDEADBEEF_CAFEF12E;
    cnt[0][1] = 1;
    wait_done(0, base + 1, 30, "read done");
    chk("read port", 64'(last_port[0]), 64'd1);
    chk("read busy cycles", 64'(last_len[0]), 64'd4);
    chk("read err", 64'(last_err[0]), 64'd0);
    chk("read m_addr", 64'(seen_addr[0]), 64'h0123);
    chk("read rdata", bi.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    chk("read grant after", 64'(bi.grant), 64'd0);

    // Write-back on port 0.
    base = done_cnt[0];
    bi.req_we[0] = 1'b1;
    bi.req_addr[0 +: 14] = 14'h3FFF;
    bi.req_wdata[0 +: 64] = 64'h1111_2222_3333_4444;
    lat[0] = 3;
    cnt[0][0] = 1;
    wait_done(0, base + 1, 30, "write done");
    chk("write saw m_we", 64'(last_we[0]), 64'd1);
    chk("write saw m_re", 64'(last_re[0]), 64'd0);
    chk("write m_addr", 64'(seen_addr[0]), 64'h3FFF);
    chk("write m_wr_data", seen_wd[0], 64'h1111_2222_3333_4444);
    chk("write rdata kept", bi.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    bi.req_we[0] = 1'b0;

    // Watchdog expiry, then m_rdy on the last allowed cycle.
    base = done_cnt[0];
    lat[0] = 0;
    cnt[0][2] = 1;
    wait_done(0, base + 1, 40, "timeout done");
    chk("timeout busy cycles", 64'(last_len[0]), 64'd8);
    chk("timeout err", 64'(last_err[0]), 64'd1);
    chk("timeout port", 64'(last_port[0]), 64'd2);
    chk("timeout rdata kept", bi.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    base = done_cnt[0];
    lat[0] = 8; rd_val[0] = 64'h0123_4567_89AB_C000;
    cnt[0][2] = 1;
    wait_done(0, base + 1, 40, "late rdy done");
    chk("late rdy busy cycles", 64'(last_len[0]), 64'd8);
    chk("late rdy err", 64'(last_err[0]), 64'd0);
    chk("late rdy rdata", bi.rsp_rdata, 64'h0123_4567_89AB_C102);

    // Reset two cycles into a port-0 read; the pointer must return to NUM_PORTS-1.
    lat[0] = 0;
    cnt[0][0] = 1;
    n = 0;
    while (!bi.m_re && n < 10) begin
      cyc();
      n++;
    end
    chk("rst read started", 64'(bi.m_re), 64'd1);
    cyc();
    base = done_cnt[0];
    rst = 1'b1;
    cnt[0][0] = 0;
    cyc();
    chk("rst m_re", 64'(bi.m_re), 64'd0);
    chk("rst grant", 64'(bi.grant), 64'd0);
    chk("rst rsp_valid", 64'(bi.rsp_valid), 64'd0);
    rst = 1'b0;
    cyc();
    chk("rst no response", 64'(done_cnt[0]), 64'(base));
    order0.delete();
    lat[0] = 1;
    cnt[0][0] = 1; cnt[0][1] = 1;
    wait_done(0, base + 2, 30, "post-rst done");
    if (order0.size() >= 2) begin
      chk("post-rst first", 64'(order0[0]), 64'd0);
      chk("post-rst second", 64'(order0[1]), 64'd1);
    end else begin
      chk("post-rst count", 64'(order0.size()), 64'd2);
    end

    // Fixed priority: port 0 starves port 1 until it stops requesting.
    bf.req_addr = {14'h021, 14'h020};
    lat[1] = 1; rd_val[1] = 64'hAAAA_BBBB_0000_0000;
    order1.delete();
    cnt[1][0] = 3; cnt[1][1] = 1;
    wait_done(1, 4, 60, "fixed done");
    chk("fixed count", 64'(order1.size()), 64'd4);
    if (order1.size() == 4) begin
      chk("fixed grant0", 64'(order1[0]), 64'd0);
      chk("fixed grant1", 64'(order1[1]), 64'd0);
      chk("fixed grant2", 64'(order1[2]), 64'd0);
      chk("fixed grant3", 64'(order1[3]), 64'd1);
    end
    chk("fixed rdata", bf.rsp_rdata, 64'hAAAA_BBBB_0000_0021);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
